// File: rtl/des_key_schedule.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | des_key_schedule : sequential DES round-key generator (PC-1, C/D rotate,  |
// |                    PC-2); optional KEY_PARITY_CHECK_EN byte parity check  |
// | Revision         : 1.0                                                    |
// +--------------------------------------------------------------------------+
module des_key_schedule #(
  parameter int AUTO_ADVANCE = 0
) (
  input  logic        Clk,
  input  logic        RstN,
  input  logic [63:0] KeyIn,
  input  logic        KeyLoad,
  input  logic        Decrypt,
  input  logic        RoundAdvance,
  output logic [47:0] RoundKey,
  output logic        RoundKeyValid,
  output logic [3:0]  RoundNum,
  output logic        Done
`ifdef KEY_PARITY_CHECK_EN
  ,
  output logic        ParityError
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Table entries are DES bit numbers (1 = MSB of the source vector).
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1_TBL[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2_TBL[i])];
    return r;
  endfunction

  // SHIFTS[idx] is 1 for rounds 1, 2, 9 and 16, otherwise 2.
  function automatic logic shift_is_two(input logic [4:0] idx);
    return !(idx == 5'd1 || idx == 5'd2 || idx == 5'd9 || idx == 5'd16);
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_t      state, state_nxt;
  logic [27:0] c_half, c_nxt;
  logic [27:0] d_half, d_nxt;
  logic [3:0]  round_num, round_nxt;
  logic        dec_mode, dec_nxt;
  logic [55:0] pc1_key;
  logic        step;
  logic        enc_two;
  logic        dec_two;

  assign pc1_key = pc1(KeyIn);
  assign step    = (AUTO_ADVANCE != 0) || RoundAdvance;
  assign enc_two = shift_is_two({1'b0, round_num} + 5'd2);
  assign dec_two = shift_is_two(5'd16 - {1'b0, round_num});

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      state     <= IDLE;
      c_half    <= '0;
      d_half    <= '0;
      round_num <= '0;
      dec_mode  <= 1'b0;
    end else begin
      state     <= state_nxt;
      c_half    <= c_nxt;
      d_half    <= d_nxt;
      round_num <= round_nxt;
      dec_mode  <= dec_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    c_nxt     = c_half;
    d_nxt     = d_half;
    round_nxt = round_num;
    dec_nxt   = dec_mode;
    if (KeyLoad) begin
      // Decryption starts from C0/D0, which equal C16/D16.
      c_nxt     = Decrypt ? pc1_key[55:28] : rotl(pc1_key[55:28], 1'b0);
      d_nxt     = Decrypt ? pc1_key[27:0]  : rotl(pc1_key[27:0], 1'b0);
      round_nxt = '0;
      dec_nxt   = Decrypt;
      state_nxt = ROUND;
    end else if (state == ROUND && step) begin
      if (round_num == 4'd15) begin
        state_nxt = DONE;
      end else begin
        c_nxt     = dec_mode ? rotr(c_half, dec_two) : rotl(c_half, enc_two);
        d_nxt     = dec_mode ? rotr(d_half, dec_two) : rotl(d_half, enc_two);
        round_nxt = round_num + 4'd1;
      end
    end
  end

  assign RoundKey      = pc2({c_half, d_half});
  assign RoundKeyValid = (state == ROUND);
  assign Done          = (state == DONE);
  assign RoundNum      = round_num;

`ifdef KEY_PARITY_CHECK_EN
  logic parity_bad;
  assign parity_bad = ~(^KeyIn[63:56]) | ~(^KeyIn[55:48]) | ~(^KeyIn[47:40]) |
                      ~(^KeyIn[39:32]) | ~(^KeyIn[31:24]) | ~(^KeyIn[23:16]) |
                      ~(^KeyIn[15:8])  | ~(^KeyIn[7:0]);

  always_ff @(posedge Clk) begin
    if (!RstN)        ParityError <= 1'b0;
    else if (KeyLoad) ParityError <= parity_bad;
  end
`else
  logic unused_parity_bits;
  assign unused_parity_bits = ^{KeyIn[56], KeyIn[48], KeyIn[40], KeyIn[32],
                                KeyIn[24], KeyIn[16], KeyIn[8],  KeyIn[0]};
`endif

endmodule
`default_nettype wire

// File: tb/tb_des_key_schedule.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_des_key_schedule : directed self-checking bench for des_key_schedule   |
// | Revision            : 1.0                                                 |
// +--------------------------------------------------------------------------+
module tb_des_key_schedule;

  logic        Clk = 1'b0;
  logic        RstN;
  logic [63:0] KeyIn;
  logic        KeyLoad;
  logic        Decrypt;
  logic        RoundAdvance;
  logic [47:0] RoundKey;
  logic        RoundKeyValid;
  logic [3:0]  RoundNum;
  logic        Done;
`ifdef KEY_PARITY_CHECK_EN
  logic        ParityError;
`endif

  int total = 0;
  int bad   = 0;

  // Published round keys for cipher key 0x133457799BBCDFF1, K1..K16.
  logic [47:0] kexp [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  des_key_schedule dut (
    .Clk          (Clk),
    .RstN         (RstN),
    .KeyIn        (KeyIn),
    .KeyLoad      (KeyLoad),
    .Decrypt      (Decrypt),
    .RoundAdvance (RoundAdvance),
    .RoundKey     (RoundKey),
    .RoundKeyValid(RoundKeyValid),
    .RoundNum     (RoundNum),
    .Done         (Done)
`ifdef KEY_PARITY_CHECK_EN
    ,
    .ParityError  (ParityError)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  initial begin
    RstN = 1'b0; KeyIn = '0; KeyLoad = 1'b0; Decrypt = 1'b0; RoundAdvance = 1'b0;
    tick(); tick();
    check("rst_valid", 64'(RoundKeyValid), 64'd0);
    check("rst_done",  64'(Done),          64'd0);
    check("rst_num",   64'(RoundNum),      64'd0);
    check("rst_key",   64'(RoundKey),      64'd0);

    // Advance ignored in IDLE
    RstN = 1'b1; RoundAdvance = 1'b1;
    tick();
    check("idle_adv_valid", 64'(RoundKeyValid), 64'd0);
    check("idle_adv_num",   64'(RoundNum),      64'd0);

    // Encrypt run with a stall at round index 3
    RoundAdvance = 1'b0; KeyIn = 64'h133457799BBCDFF1; Decrypt = 1'b0; KeyLoad = 1'b1;
    tick();
    KeyLoad = 1'b0;
    check("enc_k1",    64'(RoundKey),      64'(kexp[0]));
    check("enc_num0",  64'(RoundNum),      64'd0);
    check("enc_valid", 64'(RoundKeyValid), 64'd1);
    RoundAdvance = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("enc_key", 64'(RoundKey), 64'(kexp[i]));
      check("enc_num", 64'(RoundNum), 64'(i));
    end
    RoundAdvance = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      check("stall_key", 64'(RoundKey), 64'(kexp[3]));
      check("stall_num", 64'(RoundNum), 64'd3);
    end
    RoundAdvance = 1'b1;
    for (int i = 4; i <= 15; i++) begin
      tick();
      check("enc_key", 64'(RoundKey), 64'(kexp[i]));
      check("enc_num", 64'(RoundNum), 64'(i));
    end
    tick();
    check("enc_done",       64'(Done),          64'd1);
    check("enc_done_valid", 64'(RoundKeyValid), 64'd0);
    check("enc_done_num",   64'(RoundNum),      64'd15);
    tick(); tick();
    check("done_adv_done", 64'(Done),          64'd1);
    check("done_adv_vld",  64'(RoundKeyValid), 64'd0);
    check("done_adv_num",  64'(RoundNum),      64'd15);

    // Decrypt run; load coincides with RoundAdvance, Decrypt flips mid-run
    Decrypt = 1'b1; KeyLoad = 1'b1; RoundAdvance = 1'b1;
    tick();
    KeyLoad = 1'b0; Decrypt = 1'b0;
    check("dec_k16",   64'(RoundKey),      64'(kexp[15]));
    check("dec_num0",  64'(RoundNum),      64'd0);
    check("dec_valid", 64'(RoundKeyValid), 64'd1);
    check("dec_done0", 64'(Done),          64'd0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("dec_key", 64'(RoundKey), 64'(kexp[15 - i]));
      check("dec_num", 64'(RoundNum), 64'(i));
    end
    tick();
    check("dec_done",  64'(Done),          64'd1);
    check("dec_valid", 64'(RoundKeyValid), 64'd0);

    // Abort at round index 7 with an all-ones key (every round key is all ones)
    KeyIn = 64'h133457799BBCDFF1; Decrypt = 1'b0; KeyLoad = 1'b1; RoundAdvance = 1'b0;
    tick();
    KeyLoad = 1'b0; RoundAdvance = 1'b1;
    for (int i = 1; i <= 7; i++) tick();
    check("pre_abort_key", 64'(RoundKey), 64'(kexp[7]));
    check("pre_abort_num", 64'(RoundNum), 64'd7);
    KeyIn = 64'hFFFFFFFFFFFFFFFF; KeyLoad = 1'b1;
    tick();
    KeyLoad = 1'b0;
    check("abort_key",   64'(RoundKey),      64'hFFFFFFFFFFFF);
    check("abort_num",   64'(RoundNum),      64'd0);
    check("abort_valid", 64'(RoundKeyValid), 64'd1);
    tick();
    check("abort_adv_key", 64'(RoundKey), 64'hFFFFFFFFFFFF);
    check("abort_adv_num", 64'(RoundNum), 64'd1);

    // Reset mid-round
    RstN = 1'b0;
    tick();
    RstN = 1'b1;
    check("mid_rst_valid", 64'(RoundKeyValid), 64'd0);
    check("mid_rst_num",   64'(RoundNum),      64'd0);
    check("mid_rst_key",   64'(RoundKey),      64'd0);
    check("mid_rst_done",  64'(Done),          64'd0);
    tick();
    check("post_rst_valid", 64'(RoundKeyValid), 64'd0);

`ifdef KEY_PARITY_CHECK_EN
    RoundAdvance = 1'b0; KeyIn = 64'h123457799BBCDFF1; KeyLoad = 1'b1;
    tick();
    KeyLoad = 1'b0;
    check("parity_err", 64'(ParityError), 64'd1);
    check("parity_k1",  64'(RoundKey),    64'(kexp[0]));
    tick();
    check("parity_hold", 64'(ParityError), 64'd1);
    KeyIn = 64'h133457799BBCDFF1; KeyLoad = 1'b1;
    tick();
    KeyLoad = 1'b0;
    check("parity_ok", 64'(ParityError), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Sequential DES round-key generator, directly upstream of the f-function stage; supplies one 48-bit round key per round on its Key input.
- Applies PC-1 once to the 64-bit cipher key, then rotates the 28-bit C/D halves per round and applies PC-2.
- Produces K1..K16 in order for encryption and K16..K1 for decryption.
- Uses a valid/advance handshake so the round controller can pace delivery.

Parameters:
- AUTO_ADVANCE, 0: when 1, the key steps every cycle while valid and RoundAdvance is ignored; when 0, it steps only on RoundAdvance.

Ports:
- Clk  input  1  rising-edge clock.
- RstN  input  1  synchronous reset, active-low.
- KeyIn  input  64  cipher key, bit 63 = DES bit 1; parity bits 8,16,..,64 are ignored by PC-1.
- KeyLoad  input  1  one-cycle request to latch KeyIn and start a schedule.
- Decrypt  input  1  direction, sampled only with KeyLoad; 0 = K1 first, 1 = K16 first.
- RoundAdvance  input  1  consumer has used the current RoundKey.
- RoundKey  output  48  PC-2 output for the current round, bit 47 = PC-2 bit 1.
- RoundKeyValid  output  1  RoundKey is valid.
- RoundNum  output  4  round index r-1 (0..15) of the key currently presented.
- Done  output  1  level, high after the last key is consumed.
- ParityError  output  1  only present with KEY_PARITY_CHECK_EN.

Behaviour:
- Clock and reset: one clock, Clk; reset is synchronous and active-low on RstN.
- Reset (RstN=0 at a clock edge): state IDLE; C=D=0; RoundNum=0; RoundKeyValid=0; Done=0; ParityError=0. RoundKey is a combinational function of C/D, so it reads PC2(0,0)=0.
- Shift table SHIFTS[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (sum 28).
- States and transitions:
  - IDLE: RoundKeyValid=0. KeyLoad goes to ROUND.
  - ROUND: RoundKeyValid=1.
  - DONE: RoundKeyValid=0, Done=1. KeyLoad goes to ROUND.
- Load (KeyLoad=1 at edge N, in any state):
  - {C,D} <= PC1(KeyIn).
  - Encrypt: C,D are additionally rotated left by SHIFTS[1], i.e. C1/D1 are registered.
  - Decrypt: C0/D0 are registered unrotated, which equal C16/D16.
  - RoundNum<=0, Done<=0, state<=ROUND.
  - Result: RoundKeyValid=1 and the first key appear from cycle N+1. Latency from load to first key is 1 cycle.
- Step: occurs in ROUND when RoundAdvance=1 (or every cycle if AUTO_ADVANCE=1) and KeyLoad=0.
  - For r = RoundNum+1, with r<16:
    - Encrypt: rotate C,D left by SHIFTS[r+1].
    - Decrypt: rotate C,D right by SHIFTS[17-r].
    - RoundNum increments.
  - When r=16: state<=DONE, RoundKeyValid<=0, Done<=1. C/D hold, RoundNum holds 15.
- Rotations are 28-bit circular within C and within D independently. C and D never mix.
- Boundary conditions:
  - RoundAdvance in IDLE or DONE: ignored.
  - KeyLoad in ROUND: aborts the current schedule and restarts with the new key; KeyLoad has priority over RoundAdvance in the same cycle.
  - Reset mid-ROUND: immediate return to IDLE; no partial keys are presented afterwards.
  - Decrypt changing mid-schedule: no effect. Direction is registered only at load.
- RoundKey is stable while RoundKeyValid=1 and RoundAdvance=0.

Optional Feature:
- Macro KEY_PARITY_CHECK_EN.
- Defined:
  - On KeyLoad, each byte of KeyIn is checked for odd parity.
  - ParityError is registered high from cycle N+1 if any byte has even parity, and stays high until the next KeyLoad or reset.
  - The schedule still runs normally.
- Undefined: the ParityError port and the check logic are absent; parity bits are fully ignored.

Test Plan:
- Reset: RstN=0 for 2 cycles -> RoundKeyValid=0, Done=0, RoundNum=0, RoundKey=0x000000000000.
- Encrypt: KeyIn=0x133457799BBCDFF1, Decrypt=0, KeyLoad pulse, then RoundAdvance each cycle.
  - Next cycle: RoundKey=0x1B02EFFC7072, RoundNum=0.
  - After 1 advance: 0x79AED9DBC9E5.
  - Key 16: 0xCB3D8B0E17F5.
  - After the 16th advance: Done=1, RoundKeyValid=0.
- Decrypt: same key with Decrypt=1 -> first RoundKey=0xCB3D8B0E17F5, second=K15, last=0x1B02EFFC7072; full sequence is the exact reverse of the encrypt run.
- Stall: hold RoundAdvance=0 for 5 cycles at RoundNum=3 -> RoundKey and RoundNum unchanged; RoundAdvance ignored in DONE and IDLE.
- Abort and reset:
  - KeyLoad at RoundNum=7 with a new key -> next cycle RoundNum=0 with K1 of the new key.
  - KeyLoad and RoundAdvance in the same cycle -> reload wins.
  - RstN=0 mid-round -> IDLE.
- Parity (KEY_PARITY_CHECK_EN defined): KeyIn=0x123457799BBCDFF1 -> ParityError=1 the cycle after load; reload with 0x133457799BBCDFF1 -> ParityError=0.
